// File: rtl/quick_spi_peripheral.sv
// rtl/quick_spi_peripheral.sv - SPI peripheral (SCLK idle high, MSB first) with tx holding register and rx word output.
// Pins are oversampled through synchronizers; edges are detected one register after the last sync stage.
module quick_spi_peripheral #(
  parameter int MAX_DATA_LENGTH = 16,
  parameter int SYNC_STAGES     = 2,
  localparam int CW             = $clog2(MAX_DATA_LENGTH + 1)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       txdata_valid_i,
  output logic                       txdata_ready_o,
  input  logic [MAX_DATA_LENGTH-1:0] txdata_i,
  output logic                       rxdata_valid_o,
  input  logic                       rxdata_ready_i,
  output logic [MAX_DATA_LENGTH-1:0] rxdata_o,
  output logic [CW-1:0]              rxdata_len_o,
  output logic                       overrun_o,
  output logic                       underrun_o,
  input  logic                       sclk_i,
  input  logic                       cs_n_i,
  input  logic                       sdata_i,
  output logic                       sdata_o,
  output logic                       sdata_oe_o
);

  localparam int W  = MAX_DATA_LENGTH;
  localparam int SW = $clog2(SYNC_STAGES + 2);

  typedef enum logic [1:0] {WAIT_CS_HIGH, IDLE, ACTIVE} state_e;

  state_e               state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, sd_sync_q;
  logic                 sclk_prev_q, cs_prev_q;
  logic [SW-1:0]        settle_q, settle_d;
  logic [W-1:0]         tx_sr_q, tx_sr_d, rx_sr_q, rx_sr_d;
  logic [W-1:0]         hold_q, hold_d, rxdata_q, rxdata_d;
  logic                 hold_full_q, hold_full_d, rx_valid_q, rx_valid_d;
  logic [CW-1:0]        cnt_q, cnt_d, rx_len_q, rx_len_d;
  logic                 ovr_q, ovr_d, und_q, und_d;

  logic sclk_s, cs_s, sd_s, sclk_rise, sclk_fall, cs_rise, cs_fall, settled, handshake;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign sd_s      = sd_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;
  // The chain reset value reads "CS high"; wait for the real pin level to arrive before trusting it.
  assign settled   = (settle_q == SW'(SYNC_STAGES + 1));
  assign handshake = rx_valid_q & rxdata_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sclk_sync_q <= '1;
      cs_sync_q   <= '1;
      sd_sync_q   <= '0;
      sclk_prev_q <= 1'b1;
      cs_prev_q   <= 1'b1;
      state_q     <= WAIT_CS_HIGH;
      settle_q    <= '0;
      tx_sr_q     <= '0;
      rx_sr_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      rxdata_q    <= '0;
      rx_len_q    <= '0;
      rx_valid_q  <= 1'b0;
      cnt_q       <= '0;
      ovr_q       <= 1'b0;
      und_q       <= 1'b0;
    end else begin
      sclk_sync_q <= (sclk_sync_q << 1) | SYNC_STAGES'(sclk_i);
      cs_sync_q   <= (cs_sync_q << 1) | SYNC_STAGES'(cs_n_i);
      sd_sync_q   <= (sd_sync_q << 1) | SYNC_STAGES'(sdata_i);
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
      state_q     <= state_d;
      settle_q    <= settle_d;
      tx_sr_q     <= tx_sr_d;
      rx_sr_q     <= rx_sr_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      rxdata_q    <= rxdata_d;
      rx_len_q    <= rx_len_d;
      rx_valid_q  <= rx_valid_d;
      cnt_q       <= cnt_d;
      ovr_q       <= ovr_d;
      und_q       <= und_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    settle_d    = settle_q;
    tx_sr_d     = tx_sr_q;
    rx_sr_d     = rx_sr_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    rxdata_d    = rxdata_q;
    rx_len_d    = rx_len_q;
    rx_valid_d  = rx_valid_q;
    cnt_d       = cnt_q;
    ovr_d       = 1'b0;
    und_d       = 1'b0;

    if (handshake) rx_valid_d = 1'b0;
    if (txdata_valid_i && !hold_full_q) begin
      hold_d      = txdata_i;
      hold_full_d = 1'b1;
    end

    case (state_q)
      WAIT_CS_HIGH: begin
        if (!settled) settle_d = settle_q + 1'b1;
        else if (cs_s) state_d = IDLE;
      end
      IDLE: begin
        if (cs_fall) begin
          state_d = ACTIVE;
          cnt_d   = '0;
          rx_sr_d = '0;
          if (hold_full_q) begin
            tx_sr_d     = hold_q;
            hold_full_d = 1'b0;
          end else begin
            tx_sr_d = '0;
            und_d   = 1'b1;
          end
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_d = IDLE;
          if (cnt_q != '0) begin
            if (!rx_valid_q || handshake) begin
              rxdata_d   = rx_sr_q;
              rx_len_d   = cnt_q;
              rx_valid_d = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
          end
        end else begin
          if (sclk_rise) begin
            rx_sr_d = {rx_sr_q[W-2:0], sd_s};
            if (cnt_q != CW'(MAX_DATA_LENGTH)) cnt_d = cnt_q + 1'b1;
          end
          if (sclk_fall && cnt_q != '0) tx_sr_d = tx_sr_q << 1;
        end
      end
      default: state_d = WAIT_CS_HIGH;
    endcase
  end

  assign txdata_ready_o = ~hold_full_q;
  assign rxdata_valid_o = rx_valid_q;
  assign rxdata_o       = rxdata_q;
  assign rxdata_len_o   = rx_len_q;
  assign overrun_o      = ovr_q;
  assign underrun_o     = und_q;
  assign sdata_oe_o     = (state_q == ACTIVE);
  assign sdata_o        = (state_q == ACTIVE) & tx_sr_q[W-1];

endmodule
